// File: rtl/booth_pkg.sv
// Shared definitions for the booth_mult / product_accumulator datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: product width, default accumulator width, result count width
// and the accumulator FSM state encoding.
package booth_pkg;

  // Width of a booth_mult product (signed).
  localparam int PROD_W = 16;

  // Default signed accumulator / result width.
  localparam int ACC_W_DEF = 24;

  // Width of the per-result product counter.
  localparam int COUNT_W = 8;

  // ACC: taking products into the running sum.
  // HOLD: presenting the finished sum until downstream takes it.
  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_e;

endpackage : booth_pkg

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product source, the accumulator and the sink.
// Latency: n/a (wires only).
// Backpressure: in_ready throttles the product source, out_ready the result.
//
// master: product source / result sink side (testbench or upstream stage).
// slave : the accumulator itself.
interface product_accumulator_if #(
  parameter int ACC_W = booth_pkg::ACC_W_DEF
);

  // Product side
  logic                                 in_valid;
  logic                                 in_ready;
  logic signed [booth_pkg::PROD_W-1:0]  in_prod;
  logic                                 in_last;

  // Result side
  logic                                 out_valid;
  logic                                 out_ready;
  logic signed [ACC_W-1:0]              out_sum;
  logic [booth_pkg::COUNT_W-1:0]        out_count;
  logic                                 out_sat;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );

endinterface : product_accumulator_if

// File: rtl/product_accumulator_sat_add.sv
// Combinational signed saturating adder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: a, b (signed W) operands; sum (signed W) clamped result;
//        ovf high when the true sum did not fit and was clamped.
module sat_add #(
  parameter int W = booth_pkg::ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  localparam logic signed [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only possible when operands share a sign and the wrapped
    // result flips it; the clamp direction follows the operand sign.
    ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum = raw;
    if (ovf) begin
      sum = a[W-1] ? MIN_V : MAX_V;
    end
  end

endmodule : sat_add

// File: rtl/product_accumulator.sv
// Sums up to N_TERMS signed products into a saturating ACC_W result.
// Latency: result valid 1 cycle after the closing product is accepted.
// Backpressure: in_ready drops while a result is held; held until out_ready.
//
// Ports: clk, rst_n (async active-low); bus (slave modport) carries
//        in_valid/in_ready/in_prod/in_last and
//        out_valid/out_ready/out_sum/out_count/out_sat.
module product_accumulator
  import booth_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  product_accumulator_if.slave bus
);

  localparam logic [COUNT_W-1:0] N_TERMS_C = COUNT_W'(N_TERMS);

  acc_state_e              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [COUNT_W-1:0]      count_q, count_d;
  logic                    sat_q, sat_d;

  logic                    in_ready;
  logic                    out_valid;
  logic                    accept;
  logic                    release_res;
  logic [COUNT_W-1:0]      count_inc;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;

  // Product is sign-extended to the accumulator width before the add.
  assign prod_ext = {{(ACC_W-PROD_W){bus.in_prod[PROD_W-1]}}, bus.in_prod};

  sat_add #(.W(ACC_W)) u_sat_add (
    .a   (acc_q),
    .b   (prod_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign accept      = bus.in_valid && in_ready;
  assign release_res = out_valid && bus.out_ready;
  assign count_inc   = count_q + 1'b1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        // Close on an explicit last or once the term budget is used up.
        if (accept && (bus.in_last || (count_inc == N_TERMS_C))) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  // ---------------- FSM: outputs (state only) ----------------
  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_HOLD);
  end

  // ---------------- Datapath ----------------
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    sat_d   = sat_q;
    if (release_res) begin
      // Result taken: start the next sum clean. No product is taken in this
      // cycle because in_ready is low while holding.
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (accept) begin
      acc_d   = add_sum;
      count_d = count_inc;
      sat_d   = sat_q | add_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  // Result fields come straight from the accumulator flops; they cannot
  // change while holding since nothing is accepted in HOLD.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_sum   = acc_q;
  assign bus.out_count = count_q;
  assign bus.out_sat   = sat_q;

endmodule : product_accumulator

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: default instance (N_TERMS=8,
// ACC_W=24) driven from a vector table, plus an N_TERMS=16/ACC_W=18 instance
// for saturation and hand-written reset sequences.
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(24)) a_if ();
  product_accumulator_if #(.ACC_W(18)) b_if ();

  product_accumulator #(.N_TERMS(8), .ACC_W(24)) u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if)
  );

  product_accumulator #(.N_TERMS(16), .ACC_W(18)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if)
  );

  typedef struct {
    logic        vld;
    int          prod;
    logic        last;
    logic        ordy;
    logic        exp_irdy;
    logic        exp_ovld;
    int          exp_sum;
    int          exp_cnt;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input int p, input logic l, input logic r,
                     input logic irdy, input logic ovld, input int s,
                     input int c, input logic sat);
    vec_t e;
    e.vld = v; e.prod = p; e.last = l; e.ordy = r;
    e.exp_irdy = irdy; e.exp_ovld = ovld; e.exp_sum = s;
    e.exp_cnt = c; e.exp_sat = sat;
    vecs.push_back(e);
  endtask

  task automatic chk_a(input string tag, input logic irdy, input logic ovld,
                       input int s, input int c, input logic sat);
    chk({tag, " in_ready"},  a_if.in_ready,  irdy);
    chk({tag, " out_valid"}, a_if.out_valid, ovld);
    chk({tag, " out_sum"},   a_if.out_sum,   s);
    chk({tag, " out_count"}, a_if.out_count, c);
    chk({tag, " out_sat"},   a_if.out_sat,   sat);
  endtask

  task automatic chk_b(input string tag, input logic irdy, input logic ovld,
                       input int s, input int c, input logic sat);
    chk({tag, " in_ready"},  b_if.in_ready,  irdy);
    chk({tag, " out_valid"}, b_if.out_valid, ovld);
    chk({tag, " out_sum"},   b_if.out_sum,   s);
    chk({tag, " out_count"}, b_if.out_count, c);
    chk({tag, " out_sat"},   b_if.out_sat,   sat);
  endtask

  task automatic drive_a(input logic v, input int p, input logic l, input logic r);
    a_if.in_valid  = v;
    a_if.in_prod   = 16'(p);
    a_if.in_last   = l;
    a_if.out_ready = r;
  endtask

  task automatic drive_b(input logic v, input int p, input logic l, input logic r);
    b_if.in_valid  = v;
    b_if.in_prod   = 16'(p);
    b_if.in_last   = l;
    b_if.out_ready = r;
  endtask

  initial begin
    drive_a(0, 0, 0, 1);
    drive_b(0, 0, 0, 1);

    // Each row: inputs applied for one cycle; expectations are the outputs
    // seen during that cycle, before its rising edge.
    // Four booth products, last on the fourth.
    add(1, -5871, 0, 1, 1, 0,     0, 0, 0);
    add(1,  6200, 0, 1, 1, 0, -5871, 1, 0);
    add(1,   240, 0, 1, 1, 0,   329, 2, 0);
    add(1,    78, 1, 1, 1, 0,   569, 3, 0);
    add(0,     0, 0, 1, 0, 1,   647, 4, 0);
    add(0,     0, 0, 1, 1, 0,     0, 0, 0);
    // Eight products of 1000 close automatically at N_TERMS.
    for (int k = 0; k < 8; k++) add(1, 1000, 0, 1, 1, 0, 1000 * k, k, 0);
    // Held result with in_valid high and out_ready low for 5 cycles.
    for (int k = 0; k < 5; k++) add(1, 1000, 0, 0, 0, 1, 8000, 8, 0);
    // Handshake cycle: the offered product must not be taken.
    add(1, 1000, 0, 1, 0, 1, 8000, 8, 0);
    // Single product with last.
    add(1,    5, 1, 1, 1, 0,    0, 0, 0);
    add(0,    0, 0, 1, 0, 1,    5, 1, 0);
    // in_last without in_valid is ignored.
    add(0,  999, 1, 1, 1, 0,    0, 0, 0);
    add(0,    0, 0, 1, 1, 0,    0, 0, 0);

    // Reset state while rst_n is low.
    #3;
    chk_a("reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive_a(vecs[i].vld, vecs[i].prod, vecs[i].last, vecs[i].ordy);
      #1;
      chk_a($sformatf("vec%0d", i), vecs[i].exp_irdy, vecs[i].exp_ovld,
            vecs[i].exp_sum, vecs[i].exp_cnt, vecs[i].exp_sat);
    end
    @(negedge clk);
    drive_a(0, 0, 0, 1);

    // ---- 18-bit instance: positive clamp over 9 x 16384 ----
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      drive_b(1, 16384, (k == 9), 1);
    end
    @(negedge clk);
    drive_b(0, 0, 0, 1);
    #1;
    chk_b("pos_sat", 0, 1, 131071, 9, 1);
    @(negedge clk);
    drive_b(1, -5, 1, 1);
    #1;
    chk_b("after_sat_clear", 1, 0, 0, 0, 0);
    @(negedge clk);
    drive_b(0, 0, 0, 1);
    #1;
    chk_b("after_sat_sum", 0, 1, -5, 1, 0);

    // ---- 18-bit instance: exact minimum then negative clamp ----
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive_b(1, -32768, (k == 5), 1);
      #1;
      if (k == 5) chk_b("at_min_no_sat", 1, 0, -131072, 4, 0);
    end
    @(negedge clk);
    drive_b(0, 0, 0, 1);
    #1;
    chk_b("neg_sat", 0, 1, -131072, 5, 1);

    // ---- async reset after two accepted products ----
    @(negedge clk);
    drive_a(1, 100, 0, 1);
    @(negedge clk);
    drive_a(1, 200, 0, 1);
    @(negedge clk);
    drive_a(0, 0, 0, 1);
    #1;
    chk_a("pre_reset", 1, 0, 300, 2, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_a("async_reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(1, 78, 1, 1);
    @(negedge clk);
    drive_a(0, 0, 0, 1);
    #1;
    chk_a("post_reset_single", 0, 1, 78, 1, 0);

    // ---- reset while holding a result discards it ----
    @(negedge clk);
    drive_a(1, 7, 1, 0);
    @(negedge clk);
    drive_a(0, 0, 0, 0);
    #1;
    chk_a("hold_before_reset", 0, 1, 7, 1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_a("hold_reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive_a(0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk_a("no_result_after_reset", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_product_accumulator

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N_TERMS, default 8, meaning the maximum number of products summed per result (range 2..255).
REQ-002 SHALL have parameter ACC_W, default 24, meaning the signed accumulator and result width (range 17..32).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a product is offered on in_prod.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts the offered product this cycle.
REQ-007 SHALL have port in_prod, input, 16 bits signed: the product from the booth_mult stage (C output).
REQ-008 SHALL have port in_last, input, 1 bit: the offered product closes the current sum.
REQ-009 SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have port out_sum, output, ACC_W bits signed: the accumulated result.
REQ-012 SHALL have port out_count, output, 8 bits: the number of products in out_sum.
REQ-013 SHALL have port out_sat, output, 1 bit: saturation occurred at least once during this sum.

Function
REQ-014 SHALL implement FSM states ACC and HOLD; reset enters ACC.
REQ-015 SHALL accept a product in ACC when in_valid && in_ready; in_ready = 1 in ACC and 0 in HOLD.
REQ-016 SHALL sign-extend in_prod to ACC_W and perform a saturating add into acc; on overflow acc SHALL clamp to +2^(ACC_W-1)-1 or -2^(ACC_W-1), and sat SHALL be set sticky.
REQ-017 SHALL increment count on each accepted product.
REQ-018 SHALL move from ACC to HOLD on the accepting edge when in_last = 1 or the count reaches N_TERMS; out_valid SHALL rise on the next cycle, giving 1-cycle latency from the final accept.
REQ-019 SHALL hold out_sum, out_count and out_sat stable while out_valid && !out_ready.
REQ-020 SHALL, on out_valid && out_ready, clear acc, count and sat and return to ACC; in_ready SHALL be 1 on the following cycle, and no product SHALL be accepted in the handshake cycle.
REQ-021 SHALL ignore in_last when in_valid = 0, and SHALL ignore in_prod in HOLD.
REQ-022 SHALL treat a single accepted product with in_last = 1 as a valid sum with out_count = 1.
REQ-023 SHALL drive out_sum, out_count and out_sat directly from registers with no combinational path from inputs; in_ready SHALL depend on state only.

Reset
REQ-024 SHALL, while rst_n = 0, force state = ACC, acc = 0, count = 0, sat = 0, out_valid = 0 and in_ready = 1, regardless of clk.
REQ-025 SHALL discard any partial sum or held result on reset mid-operation, with no output handshake afterward.
REQ-026 SHALL leave reset release synchronised externally; the block needs no internal synchroniser.

Structure
REQ-027 SHALL place PROD_W = 16, the default ACC_W and the FSM state enum in the shared package booth_pkg, which is also used by booth_mult.
REQ-028 SHALL contain one sub-module, sat_add: a combinational signed ACC_W saturating adder with outputs sum and ovf.

Verification
REQ-029 Feed products -5871, 6200, 240, 78 (last on the 4th) from booth_mult operands (0x99×0x39, 0x7C×0x32, 0xC4×0xFC, 0xFA×0xF3) with out_ready = 1 -> out_sum = 647, out_count = 4, out_sat = 0, out_valid for 1 cycle.
REQ-030 Feed 8 products of 1000 with no in_last -> the result is produced automatically with out_sum = 8000 and out_count = 8; in_ready = 0 while the result is held.
REQ-031 Set ACC_W = 18 and N_TERMS = 16, then feed 9×16384 with last on the 9th -> out_sum = 131071, out_sat = 1; the next sum starts with sat = 0.
REQ-032 Hold out_ready = 0 for 5 cycles with in_valid = 1 -> out_* stay stable and no input is accepted; accept, then the next sum starts from 0.
REQ-033 Assert rst_n = 0 asynchronously after 2 accepted products -> outputs reset immediately; a subsequent single product 78 with last -> out_sum = 78, out_count = 1.
